// File: rtl/mem_req_ctrl.sv
// mem_req_ctrl: upstream request controller placed in front of the memory's
// strobe/ack ports. Commands (read/write) are accepted over a valid/ready
// port into a small FIFO and issued to the memory one at a time. Every issued
// command yields exactly one response (read data or write completion), with
// rsp_err_o flagging an ack timeout.
//
// Ports:
//   clk_i, arst_i               clock, asynchronous active-high reset
//   cmd_valid_i/cmd_ready_o     command handshake
//   cmd_we_i, cmd_index_i,
//   cmd_data_i                  command fields (data ignored for reads)
//   rsp_valid_o/rsp_ready_i     response handshake
//   rsp_we_o, rsp_data_o,
//   rsp_err_o                   response fields
//   wr_o, ack_wr_i, wr_index_o,
//   wr_data_o                   memory write port
//   rd_o, ack_rd_i, rd_index_o,
//   rd_data_i                   memory read port
module mem_req_ctrl #(
  parameter int WORD_WIDTH  = 4,
  parameter int INDEX_WIDTH = 4,
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT     = 15
) (
  input  logic                   clk_i,
  input  logic                   arst_i,
  input  logic                   cmd_valid_i,
  output logic                   cmd_ready_o,
  input  logic                   cmd_we_i,
  input  logic [INDEX_WIDTH-1:0] cmd_index_i,
  input  logic [WORD_WIDTH-1:0]  cmd_data_i,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic                   rsp_we_o,
  output logic [WORD_WIDTH-1:0]  rsp_data_o,
  output logic                   rsp_err_o,
  output logic                   wr_o,
  input  logic                   ack_wr_i,
  output logic [INDEX_WIDTH-1:0] wr_index_o,
  output logic [WORD_WIDTH-1:0]  wr_data_o,
  output logic                   rd_o,
  input  logic                   ack_rd_i,
  output logic [INDEX_WIDTH-1:0] rd_index_o,
  input  logic [WORD_WIDTH-1:0]  rd_data_i
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RSP} state_t;

  // Command FIFO storage carries no reset; only pointers/count are control.
  logic                   fifo_we    [FIFO_DEPTH];
  logic [INDEX_WIDTH-1:0] fifo_index [FIFO_DEPTH];
  logic [WORD_WIDTH-1:0]  fifo_data  [FIFO_DEPTH];
  logic [PW-1:0]          wr_ptr, rd_ptr;
  logic [CW-1:0]          count;
  logic                   full, empty, push, pop;

  state_t                 state_q, state_d;
  logic [TW-1:0]          cnt_q, cnt_d;
  logic                   req_we_q, req_we_d;
  logic                   wr_q, wr_d, rd_q, rd_d;
  logic [INDEX_WIDTH-1:0] wr_index_q, wr_index_d, rd_index_q, rd_index_d;
  logic [WORD_WIDTH-1:0]  wr_data_q, wr_data_d;
  logic                   rsp_valid_q, rsp_valid_d, rsp_we_q, rsp_we_d;
  logic                   rsp_err_q, rsp_err_d;
  logic [WORD_WIDTH-1:0]  rsp_data_q, rsp_data_d;
  logic                   ack_hit;

  assign full        = (count == FULL_CNT);
  assign empty       = (count == '0);
  assign cmd_ready_o = !full && !arst_i;
  assign push        = cmd_valid_i && cmd_ready_o;

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_we[wr_ptr]    <= cmd_we_i;
      fifo_index[wr_ptr] <= cmd_index_i;
      fifo_data[wr_ptr]  <= cmd_data_i;
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Only the ack matching the pending direction ends a transaction.
  assign ack_hit = req_we_q ? ack_wr_i : ack_rd_i;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_we_d    = req_we_q;
    wr_d        = wr_q;
    rd_d        = rd_q;
    wr_index_d  = wr_index_q;
    wr_data_d   = wr_data_q;
    rd_index_d  = rd_index_q;
    rsp_valid_d = rsp_valid_q;
    rsp_we_d    = rsp_we_q;
    rsp_err_d   = rsp_err_q;
    rsp_data_d  = rsp_data_q;
    pop         = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!empty) begin
          pop      = 1'b1;
          state_d  = S_REQ;
          req_we_d = fifo_we[rd_ptr];
          if (fifo_we[rd_ptr]) begin
            wr_d       = 1'b1;
            wr_index_d = fifo_index[rd_ptr];
            wr_data_d  = fifo_data[rd_ptr];
          end else begin
            rd_d       = 1'b1;
            rd_index_d = fifo_index[rd_ptr];
          end
        end
      end
      S_REQ: begin
        if (ack_hit || (cnt_q == TO_LAST)) begin
          // Transaction ends: drop the strobe and present the response.
          state_d     = S_RSP;
          wr_d        = 1'b0;
          rd_d        = 1'b0;
          wr_index_d  = '0;
          wr_data_d   = '0;
          rd_index_d  = '0;
          rsp_valid_d = 1'b1;
          rsp_we_d    = req_we_q;
          rsp_err_d   = !ack_hit;
          rsp_data_d  = (ack_hit && !req_we_q) ? rd_data_i : '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RSP: begin
        if (rsp_ready_i) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      req_we_q    <= 1'b0;
      wr_q        <= 1'b0;
      rd_q        <= 1'b0;
      wr_index_q  <= '0;
      wr_data_q   <= '0;
      rd_index_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_we_q    <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_we_q    <= req_we_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      wr_index_q  <= wr_index_d;
      wr_data_q   <= wr_data_d;
      rd_index_q  <= rd_index_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_we_q    <= rsp_we_d;
      rsp_err_q   <= rsp_err_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign wr_o        = wr_q;
  assign rd_o        = rd_q;
  assign wr_index_o  = wr_index_q;
  assign wr_data_o   = wr_data_q;
  assign rd_index_o  = rd_index_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_we_o    = rsp_we_q;
  assign rsp_err_o   = rsp_err_q;
  assign rsp_data_o  = rsp_data_q;

endmodule
